exe_lane_reconfig_ctrl: RTL and testbench

- Sequences dynamic activation and deactivation of execution lanes (the clock-gated ctrl, simple, complex and memory pipes).
- Accepts a target lane mask, blocks issue to the affected lanes, and waits for the lanes being turned off to drain through RegRead, RegReadExecute and Writeback.
- Then updates the per-lane laneActive_i enables and holds issue blocked through a wake-up settle window before releasing.
- Sits between the reconfiguration manager and the issue queue / execution pipes.

---
 rtl/exe_lane_reconfig_ctrl.sv | 170 +++++++++++++++++
 tb/tb_exe_lane_reconfig_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_lane_reconfig_ctrl.sv
// Execution-lane reconfiguration sequencer: block issue, drain lanes going off, gate, settle, release.
// Optional drain watchdog enabled by defining EXE_LANE_DRAIN_TIMEOUT_EN.
module exe_lane_reconfig_ctrl #(
    parameter int NUM_LANES      = 4,
    parameter int DRAIN_CYCLES   = 3,
    parameter int WAKE_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reconfigReq_i,
    input  logic [NUM_LANES-1:0] targetMask_i,
    input  logic [NUM_LANES-1:0] laneBusy_i,
    output logic [NUM_LANES-1:0] laneActive_o,
    output logic [NUM_LANES-1:0] issueBlock_o,
    output logic                 reconfigBusy_o,
    output logic                 reconfigDone_o,
    output logic                 reconfigErr_o
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int WAKE_W  = $clog2(WAKE_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_MAX  = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [WAKE_W-1:0]  WAKE_LAST  = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [NUM_LANES-1:0] LANE0    = NUM_LANES'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        GATE  = 3'd2,
        WAKE  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state, stateNext;
    logic [NUM_LANES-1:0] cur, curNext;
    logic [NUM_LANES-1:0] tgt, tgtNext;
    logic [NUM_LANES-1:0] issueBlock, issueBlockNext;
    logic [DRAIN_W-1:0]   drainCnt, drainCntNext;
    logic [WAKE_W-1:0]    wakeCnt, wakeCntNext;
    logic                 doneQ, doneNext;

    logic [NUM_LANES-1:0] reqTgt, reqOff, reqOn;
    logic [NUM_LANES-1:0] offMask, onMask;
    logic                 drainIdle;

    // Lane 0 always stays powered, so its target bit is forced on at sampling.
    assign reqTgt    = targetMask_i | LANE0;
    assign reqOff    = cur & ~reqTgt;
    assign reqOn     = reqTgt & ~cur;
    assign offMask   = cur & ~tgt;
    assign onMask    = tgt & ~cur;
    assign drainIdle = ((laneBusy_i & offMask) == '0);

`ifdef EXE_LANE_DRAIN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wdCnt, wdCntNext;
    logic            errQ, errNext;
`endif

    always_comb begin
        stateNext      = state;
        curNext        = cur;
        tgtNext        = tgt;
        issueBlockNext = issueBlock;
        drainCntNext   = '0;
        wakeCntNext    = '0;
        doneNext       = 1'b0;
`ifdef EXE_LANE_DRAIN_TIMEOUT_EN
        wdCntNext      = '0;
        errNext        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (reconfigReq_i) begin
                    tgtNext = reqTgt;
                    if (reqTgt == cur) begin
                        stateNext = DONE;
                    end else begin
                        issueBlockNext = reqOff | reqOn;
                        // Nothing to drain on a pure enable: straight to gating.
                        stateNext      = (reqOff == '0) ? GATE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drainIdle) begin
                    drainCntNext = (drainCnt == DRAIN_MAX) ? drainCnt : drainCnt + DRAIN_W'(1);
                    if (drainCnt >= DRAIN_LAST) begin
                        stateNext = GATE;
                    end
                end
`ifdef EXE_LANE_DRAIN_TIMEOUT_EN
                wdCntNext = (wdCnt == TO_MAX) ? wdCnt : wdCnt + TO_W'(1);
                // Watchdog wins over a drain that completes on the same cycle.
                if (wdCnt >= TO_LAST) begin
                    stateNext      = IDLE;
                    issueBlockNext = '0;
                    errNext        = 1'b1;
                end
`endif
            end
            GATE: begin
                curNext   = tgt;
                stateNext = (onMask != '0) ? WAKE : DONE;
            end
            WAKE: begin
                if (wakeCnt >= WAKE_LAST) begin
                    stateNext = DONE;
                end else begin
                    wakeCntNext = wakeCnt + WAKE_W'(1);
                end
            end
            DONE: begin
                issueBlockNext = '0;
                stateNext      = IDLE;
            end
            default: begin
                stateNext      = IDLE;
                issueBlockNext = '0;
            end
        endcase
        doneNext = (stateNext == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cur        <= '1;
            issueBlock <= '0;
            drainCnt   <= '0;
            wakeCnt    <= '0;
            doneQ      <= 1'b0;
`ifdef EXE_LANE_DRAIN_TIMEOUT_EN
            wdCnt      <= '0;
            errQ       <= 1'b0;
`endif
        end else begin
            state      <= stateNext;
            cur        <= curNext;
            issueBlock <= issueBlockNext;
            drainCnt   <= drainCntNext;
            wakeCnt    <= wakeCntNext;
            doneQ      <= doneNext;
`ifdef EXE_LANE_DRAIN_TIMEOUT_EN
            wdCnt      <= wdCntNext;
            errQ       <= errNext;
`endif
        end
    end

    // Target is re-latched on every accepted request and only read outside IDLE.
    always_ff @(posedge clk) begin
        tgt <= tgtNext;
    end

    assign laneActive_o   = cur;
    assign issueBlock_o   = issueBlock;
    assign reconfigBusy_o = (state != IDLE);
    assign reconfigDone_o = doneQ;
`ifdef EXE_LANE_DRAIN_TIMEOUT_EN
    assign reconfigErr_o  = errQ;
`else
    assign reconfigErr_o  = 1'b0;
`endif

endmodule

// File: tb/tb_exe_lane_reconfig_ctrl.sv
// Scoreboard bench for exe_lane_reconfig_ctrl: completion/error pulses are matched against queued expectations.
module tb_exe_lane_reconfig_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic [3:0] target = '0;
    logic [3:0] busy = '0;
    logic [3:0] laneActive;
    logic [3:0] issueBlock;
    logic       rBusy, done, err;

    exe_lane_reconfig_ctrl #(
        .NUM_LANES(4), .DRAIN_CYCLES(3), .WAKE_CYCLES(2), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .reconfigReq_i(req),
        .targetMask_i(target),
        .laneBusy_i(busy),
        .laneActive_o(laneActive),
        .issueBlock_o(issueBlock),
        .reconfigBusy_o(rBusy),
        .reconfigDone_o(done),
        .reconfigErr_o(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic       isErr;
        logic [3:0] active;
    } exp_t;
    exp_t sbq[$];

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    endtask

    // Monitor: every done/err pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && (done || err)) begin
            if (sbq.size() == 0) begin
                check("unexpected pulse {done,err}", {30'd0, done, err}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("pulse cycle", cyc, e.at);
                check("pulse is err", err, e.isErr);
                check("pulse is done", done, !e.isErr);
                check("laneActive at pulse", laneActive, e.active);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tickTo(input int c);
        while (cyc < c) tick(1);
    endtask

    // Issues a one-cycle request; off < 0 means no pulse is expected.
    task automatic request(input logic [3:0] m, input int off, input logic isErr,
                           input logic [3:0] active, output int t);
        exp_t e;
        t = cyc;
        if (off >= 0) begin
            e.at = t + off;
            e.isErr = isErr;
            e.active = active;
            sbq.push_back(e);
        end
        req = 1'b1;
        target = m;
        tick(1);
        req = 1'b0;
        target = '0;
    endtask

    task automatic waitIdle(input int budget);
        int k = 0;
        while ((rBusy || sbq.size() != 0) && k < budget) begin
            tick(1);
            k++;
        end
        check("idle within budget", {31'd0, (rBusy || sbq.size() != 0)}, 32'd0);
        tick(1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int t;
        tick(3);
        check("reset laneActive", laneActive, 4'b1111);
        check("reset issueBlock", issueBlock, 4'b0000);
        check("reset busy", rBusy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset err", err, 1'b0);
        reset = 1'b1;
        tick(2);

        // Pure disable, lanes idle: gate and done at T+5.
        request(4'b0011, 5, 1'b0, 4'b0011, t);
        check("dis issueBlock T+1", issueBlock, 4'b1100);
        check("dis busy T+1", rBusy, 1'b1);
        check("dis laneActive T+1", laneActive, 4'b1111);
        tickTo(t + 4);
        check("dis laneActive T+4", laneActive, 4'b1111);
        tickTo(t + 6);
        check("dis issueBlock released", issueBlock, 4'b0000);
        check("dis busy released", rBusy, 1'b0);
        waitIdle(20);

        // Pure enable with bit 0 cleared in the request: forced to 4'b1111.
        request(4'b1110, 4, 1'b0, 4'b1111, t);
        check("en issueBlock T+1", issueBlock, 4'b1100);
        check("en laneActive T+1", laneActive, 4'b0011);
        tickTo(t + 2);
        check("en laneActive T+2", laneActive, 4'b1111);
        check("en issueBlock held in WAKE", issueBlock, 4'b1100);
        tickTo(t + 5);
        check("en issueBlock released", issueBlock, 4'b0000);
        waitIdle(20);

        // Lane 3 busy T+1..T+3 restarts drain; lane 1 toggling and a stray request are ignored.
        request(4'b0011, 8, 1'b0, 4'b0011, t);
        for (int k = 1; k <= 8; k++) begin
            if (k == 7) check("busy laneActive T+7", laneActive, 4'b1111);
            busy[3] = (k <= 3);
            busy[1] = k[0];
            req     = (k == 2);
            target  = (k == 2) ? 4'b0001 : 4'b0000;
            tick(1);
        end
        req = 1'b0;
        busy = '0;
        check("busy laneActive T+9", laneActive, 4'b0011);
        waitIdle(20);

        request(4'b1110, 4, 1'b0, 4'b1111, t);
        waitIdle(20);

        // No-op request: done at T+1, busy exactly one cycle, no blocking.
        request(4'b1111, 1, 1'b0, 4'b1111, t);
        check("noop busy T+1", rBusy, 1'b1);
        check("noop issueBlock T+1", issueBlock, 4'b0000);
        tick(1);
        check("noop busy T+2", rBusy, 1'b0);
        waitIdle(20);

        request(4'b0101, 5, 1'b0, 4'b0101, t);
        waitIdle(20);

        // Mixed: lane 2 off, lane 1 on -> drain, gate at T+4, two wake cycles, done T+7.
        request(4'b0011, 7, 1'b0, 4'b0011, t);
        check("mix issueBlock T+1", issueBlock, 4'b0110);
        tickTo(t + 4);
        check("mix laneActive T+4", laneActive, 4'b0101);
        tickTo(t + 5);
        check("mix laneActive T+5", laneActive, 4'b0011);
        waitIdle(20);

        // Reset asserted during WAKE of a mixed transition.
        request(4'b0101, -1, 1'b0, 4'b0000, t);
        tickTo(t + 5);
        check("pre-reset laneActive in WAKE", laneActive, 4'b0101);
        check("pre-reset busy in WAKE", rBusy, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("mid reset laneActive", laneActive, 4'b1111);
        check("mid reset issueBlock", issueBlock, 4'b0000);
        check("mid reset busy", rBusy, 1'b0);
        tick(1);
        reset = 1'b1;
        tick(4);
        check("post reset laneActive", laneActive, 4'b1111);
        check("post reset busy", rBusy, 1'b0);

`ifdef EXE_LANE_DRAIN_TIMEOUT_EN
        // Lane 2 held busy: watchdog aborts, err visible at T+65, lanes unchanged.
        busy = 4'b0100;
        request(4'b0011, 65, 1'b1, 4'b1111, t);
        check("to issueBlock T+1", issueBlock, 4'b1100);
        tickTo(t + 64);
        check("to busy T+64", rBusy, 1'b1);
        tickTo(t + 66);
        check("to issueBlock after abort", issueBlock, 4'b0000);
        check("to busy after abort", rBusy, 1'b0);
        check("to laneActive after abort", laneActive, 4'b1111);
        busy = '0;
        waitIdle(20);
`endif

        check("scoreboard empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
